// File: rtl/button_parser.sv
`default_nettype none
// ============================================================================
// Module      : button_parser
// Description : Push-button conditioning front end. Each raw, asynchronous,
//               bouncing button level is synchronised, debounced against a
//               shared sample tick and edge-detected into a single-cycle
//               press pulse.
//
// Parameters  : WIDTH          - number of independent buttons
//               SAMPLE_CNT_MAX - clocks per sample tick
//               PULSE_CNT_MAX  - consecutive high sample ticks to accept a press
//
// Ports       : clk   in  1      system clock
//               rst   in  1      asynchronous, active-low reset
//               in    in  WIDTH  raw button levels (async to clk, active-high)
//               out   out WIDTH  one-clk pulse per accepted press
//               level out WIDTH  debounced button level
//
// Revision    : 1.0 - initial release
// ============================================================================
module button_parser #(
    parameter int WIDTH          = 4,
    parameter int SAMPLE_CNT_MAX = 25000,
    parameter int PULSE_CNT_MAX  = 150
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] level
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // A divide-by-one tick would give a zero-width counter; keep at least one
    // bit so the counter declaration stays legal in that corner case.
    localparam int c_TICK_W = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
    localparam int c_CNT_W  = $clog2(PULSE_CNT_MAX + 1);

    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(SAMPLE_CNT_MAX - 1);
    localparam logic [c_TICK_W-1:0] c_TICK_ONE  = c_TICK_W'(1);
    localparam logic [c_CNT_W-1:0]  c_CNT_SAT   = c_CNT_W'(PULSE_CNT_MAX);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE   = c_CNT_W'(1);

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0]    r_s1;          // first synchroniser stage
    logic [WIDTH-1:0]    r_s2;          // second synchroniser stage (used downstream)
    logic [c_TICK_W-1:0] r_tick_cnt;    // shared sample-tick divider
    logic                w_tick;        // one-cycle sample strobe
    logic [c_CNT_W-1:0]  r_cnt [WIDTH]; // per-button saturating debounce counter
    logic [WIDTH-1:0]    w_level;       // debounced level, decoded from r_cnt
    logic [WIDTH-1:0]    r_level_q;     // previous-cycle debounced level

    // ------------------------------------------------------------------------
    // Two-flop synchroniser. The raw inputs are asynchronous to clk, so only
    // r_s2 may be looked at by any other logic.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= in;
            r_s2 <= r_s1;
        end
    end

    // ------------------------------------------------------------------------
    // Free-running sample-tick divider, shared by every button. It is not
    // aligned to any press, which is why acceptance latency varies by up to
    // one sample period.
    // ------------------------------------------------------------------------
    assign w_tick = (r_tick_cnt == c_TICK_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + c_TICK_ONE;
        end
    end

    // ------------------------------------------------------------------------
    // Debounce counters. A low synchronised sample clears the count on the
    // very next clock, not on the next tick: any dip during counting, however
    // short, forces the full hold time to be re-accumulated. The counter
    // saturates so a long hold never rolls over into a second press.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '{default: '0};
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (!r_s2[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_tick && (r_cnt[i] < c_CNT_SAT)) begin
                    r_cnt[i] <= r_cnt[i] + c_CNT_ONE;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Debounced level is a pure decode of the counter register, so it drops
    // asynchronously together with the counters when reset is applied.
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_level
            assign w_level[gi] = (r_cnt[gi] == c_CNT_SAT);
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Rising-edge detect on the debounced level: one pulse per accepted press,
    // none on release, none while held.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_level_q <= '0;
        end else begin
            r_level_q <= w_level;
        end
    end

    assign level = w_level;
    assign out   = w_level & ~r_level_q;

endmodule
`default_nettype wire

// File: tb/tb_button_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_parser
// Description : Directed self-checking bench for button_parser with a
//               4-clock sample tick and a 3-tick acceptance threshold, so one
//               press is accepted 9..12 cycles after the synchronised input
//               rises (11..14 cycles after the raw input is driven).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_parser;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] in  = 4'b0000;
    logic [3:0] out;
    logic [3:0] level;

    button_parser #(
        .WIDTH          (4),
        .SAMPLE_CNT_MAX (4),
        .PULSE_CNT_MAX  (3)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .in    (in),
        .out   (out),
        .level (level)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Per-button observations, sampled on the falling edge.
    int         pulse_tot [4] = '{default: 0};
    int         lvl_tot   [4] = '{default: 0};
    int         rise_cyc  [4] = '{default: 0};
    int         pulse_cyc [4] = '{default: 0};
    logic [3:0] lvl_prev      = 4'b0000;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (out[i]) begin
                pulse_tot[i] <= pulse_tot[i] + 1;
                pulse_cyc[i] <= cyc;
            end
            if (level[i]) lvl_tot[i] <= lvl_tot[i] + 1;
            if (level[i] && !lvl_prev[i]) rise_cyc[i] <= cyc;
        end
        lvl_prev <= level;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        logic ok;
        ok = (obs >= lo) && (obs <= hi);
        n_checks++;
        assert (ok === 1'b1) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    int pbase [4];
    int lbase [4];
    int d0;

    initial begin
        // ---------------- reset state ----------------
        rst = 1'b0;
        in  = 4'b0000;
        wait_neg(3);
        check("reset_out", int'(out), 0);
        check("reset_level", int'(level), 0);
        rst = 1'b1;
        wait_neg(4);

        // ---------------- clean press on bit 0 ----------------
        pbase = pulse_tot;
        d0    = cyc;
        in[0] = 1'b1;
        wait_neg(40);
        check("clean_pulses0", pulse_tot[0] - pbase[0], 1);
        check_range("clean_latency0", rise_cyc[0] - d0, 11, 14);
        check("clean_pulse_at_rise", pulse_cyc[0], rise_cyc[0]);
        for (int i = 1; i < 4; i++)
            check($sformatf("clean_other_pulses%0d", i), pulse_tot[i] - pbase[i], 0);
        check("clean_level_held", int'(level[0]), 1);
        in[0] = 1'b0;
        wait_neg(2);
        check("clean_level_2_after_drop", int'(level[0]), 1);
        wait_neg(1);
        check("clean_level_3_after_drop", int'(level[0]), 0);
        wait_neg(5);
        check("clean_no_release_pulse", pulse_tot[0] - pbase[0], 1);

        // ---------------- bounce on bit 1 ----------------
        pbase = pulse_tot;
        lbase = lvl_tot;
        for (int k = 0; k < 5; k++) begin
            in[1] = 1'b1;
            wait_neg(3);
            in[1] = 1'b0;
            wait_neg(3);
        end
        check("bounce_no_pulse", pulse_tot[1] - pbase[1], 0);
        check("bounce_no_level", lvl_tot[1] - lbase[1], 0);
        d0    = cyc;
        in[1] = 1'b1;
        wait_neg(20);
        check("bounce_final_pulses", pulse_tot[1] - pbase[1], 1);
        check_range("bounce_latency", rise_cyc[1] - d0, 11, 14);
        in[1] = 1'b0;
        wait_neg(6);

        // ---------------- hold and re-press on bit 2 ----------------
        pbase = pulse_tot;
        in[2] = 1'b1;
        wait_neg(100);
        check("hold_single_pulse", pulse_tot[2] - pbase[2], 1);
        in[2] = 1'b0;
        wait_neg(2);
        check("hold_level_2_after_drop", int'(level[2]), 1);
        wait_neg(1);
        check("hold_level_3_after_drop", int'(level[2]), 0);
        wait_neg(2);
        in[2] = 1'b1;
        wait_neg(20);
        check("repress_pulses", pulse_tot[2] - pbase[2], 2);
        check("repress_level", int'(level[2]), 1);
        in = 4'b0000;
        wait_neg(6);

        // ---------------- simultaneous presses ----------------
        pbase = pulse_tot;
        in    = 4'b1111;
        wait_neg(20);
        for (int i = 0; i < 4; i++)
            check($sformatf("simul_pulses%0d", i), pulse_tot[i] - pbase[i], 1);
        for (int i = 1; i < 4; i++)
            check($sformatf("simul_same_cycle%0d", i), pulse_cyc[i], pulse_cyc[0]);
        in = 4'b0000;
        wait_neg(6);

        // ---------------- asynchronous reset mid-count ----------------
        in[3] = 1'b1;
        wait_neg(20);
        check("pre_reset_level3", int'(level[3]), 1);
        in[0] = 1'b1;
        wait_neg(10);          // exactly two ticks seen on bit 0, level[0] still 0
        check("pre_reset_level0", int'(level[0]), 0);
        #2 rst = 1'b0;         // between clock edges
        #1;
        check("async_reset_out", int'(out), 0);
        check("async_reset_level", int'(level), 0);
        wait_neg(3);
        check("in_reset_level", int'(level), 0);
        pbase = pulse_tot;
        d0    = cyc;
        rst   = 1'b1;
        wait_neg(20);
        check("post_reset_pulses0", pulse_tot[0] - pbase[0], 1);
        check("post_reset_latency0", rise_cyc[0] - d0, 12);
        check("post_reset_pulses3", pulse_tot[3] - pbase[3], 1);
        in = 4'b0000;
        wait_neg(6);

        // ---------------- short glitch on bit 3 ----------------
        pbase = pulse_tot;
        lbase = lvl_tot;
        in[3] = 1'b1;
        wait_neg(6);
        in[3] = 1'b0;
        wait_neg(20);
        check("glitch_no_pulse", pulse_tot[3] - pbase[3], 0);
        check("glitch_no_level", lvl_tot[3] - lbase[3], 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
